// File: rtl/wavetable_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wavetable_rom_arbiter
//  Brief    : Round-robin arbiter sharing one band-limited wavetable ROM
//             between oscillator voices. Maps the granted voice's note to a
//             band, issues the {band, phase} read and returns the sample
//             tagged with voice id and band after the ROM latency.
//  Revision : 1.0 - initial release
// ============================================================================
module wavetable_rom_arbiter #(
  parameter int NUM_VOICES     = 8,
  parameter int MIDI_NOTES     = 128,
  parameter int NUM_BANDS      = 22,
  parameter int NOTES_PER_BAND = 6,
  parameter int PHASE_BITS     = 10,
  parameter int SAMPLE_BITS    = 16,
  parameter int ROM_LATENCY    = 2,
  localparam int NOTE_W        = $clog2(MIDI_NOTES),
  localparam int BAND_W        = $clog2(NUM_BANDS),
  localparam int VOICE_W       = $clog2(NUM_VOICES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_VOICES-1:0]          req_valid,
  input  logic [NUM_VOICES*NOTE_W-1:0]   req_note,
  input  logic [NUM_VOICES*PHASE_BITS-1:0] req_phase,
  output logic [NUM_VOICES-1:0]          req_ready,
  output logic                           rom_en,
  output logic [BAND_W+PHASE_BITS-1:0]   rom_addr,
  input  logic [SAMPLE_BITS-1:0]         rom_data,
  output logic                           rsp_valid,
  output logic [VOICE_W-1:0]             rsp_voice,
  output logic [BAND_W-1:0]              rsp_band,
  output logic [SAMPLE_BITS-1:0]         rsp_sample
);

  localparam logic [VOICE_W-1:0] c_last_voice = VOICE_W'(NUM_VOICES - 1);
  localparam logic [NOTE_W-1:0]  c_npb        = NOTE_W'(NOTES_PER_BAND);
  localparam logic [NOTE_W-1:0]  c_nbands     = NOTE_W'(NUM_BANDS);
  localparam logic [NOTE_W-1:0]  c_top_band   = NOTE_W'(NUM_BANDS - 1);

  // Round-robin pointer: first voice examined in the next search
  logic [VOICE_W-1:0]    r_ptr;

  // Arbitration results for the current cycle
  logic [NUM_VOICES-1:0] w_grant;
  logic [VOICE_W-1:0]    w_gnt_id;
  logic                  w_gnt_vld;
  logic [VOICE_W-1:0]    w_idx;

  // Granted voice's request fields and derived band
  logic [NOTE_W-1:0]     w_note;
  logic [NOTE_W-1:0]     w_quot;
  logic [NOTE_W-1:0]     w_band_full;
  logic [BAND_W-1:0]     w_band;
  logic [PHASE_BITS-1:0] w_phase;

  // Read address register; holds between strobes
  logic [BAND_W+PHASE_BITS-1:0] r_rom_addr;

  // Side pipeline: stage 0 lines up with rom_en, stage ROM_LATENCY with
  // the cycle in which rom_data is valid for that read
  logic [ROM_LATENCY:0]              r_pv;
  logic [ROM_LATENCY:0][VOICE_W-1:0] r_pvoice;
  logic [ROM_LATENCY:0][BAND_W-1:0]  r_pband;

  // Response registers
  logic                   r_rsp_valid;
  logic [VOICE_W-1:0]     r_rsp_voice;
  logic [BAND_W-1:0]      r_rsp_band;
  logic [SAMPLE_BITS-1:0] r_rsp_sample;

  // Search requests upward from the pointer with wrap; first hit wins
  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      w_idx = VOICE_W'((int'(r_ptr) + k) % NUM_VOICES);
      if (!w_gnt_vld && req_valid[w_idx]) begin
        w_gnt_vld       = 1'b1;
        w_gnt_id        = w_idx;
        w_grant[w_idx]  = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;

  // Note-to-band mapping for the granted voice, clamped to the top band
  always_comb begin
    w_note      = req_note[w_gnt_id*NOTE_W +: NOTE_W];
    w_phase     = req_phase[w_gnt_id*PHASE_BITS +: PHASE_BITS];
    w_quot      = w_note / c_npb;
    w_band_full = (w_quot >= c_nbands) ? c_top_band : w_quot;
    w_band      = w_band_full[BAND_W-1:0];
  end

  // Advance the pointer past the granted voice; hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_id == c_last_voice) ? '0 : w_gnt_id + VOICE_W'(1);
    end
  end

  // Issue the ROM read and carry its tag through the latency pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_pv       <= '0;
      r_pvoice   <= '0;
      r_pband    <= '0;
    end else begin
      r_pv[0] <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rom_addr  <= {w_band, w_phase};
        r_pvoice[0] <= w_gnt_id;
        r_pband[0]  <= w_band;
      end
      for (int j = 1; j <= ROM_LATENCY; j++) begin
        r_pv[j]     <= r_pv[j-1];
        r_pvoice[j] <= r_pvoice[j-1];
        r_pband[j]  <= r_pband[j-1];
      end
    end
  end

  // Capture ROM data alongside its tag; fields hold when no response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_voice  <= '0;
      r_rsp_band   <= '0;
      r_rsp_sample <= '0;
    end else begin
      r_rsp_valid <= r_pv[ROM_LATENCY];
      if (r_pv[ROM_LATENCY]) begin
        r_rsp_voice  <= r_pvoice[ROM_LATENCY];
        r_rsp_band   <= r_pband[ROM_LATENCY];
        r_rsp_sample <= rom_data;
      end
    end
  end

  assign rom_en     = r_pv[0];
  assign rom_addr   = r_rom_addr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_voice  = r_rsp_voice;
  assign rsp_band   = r_rsp_band;
  assign rsp_sample = r_rsp_sample;

endmodule
`default_nettype wire

// File: doc/wavetable_rom_arbiter.md
Name: wavetable_rom_arbiter

Overview:
- Shares one band-limited wavetable ROM between NUM_VOICES oscillator voices.
- Each voice requests a sample with its MIDI note and phase index; the block grants one voice per cycle round-robin.
- For the granted voice it maps note to band, forms the ROM address {band, phase}, and tracks the ROM read latency.
- Returns the sample tagged with voice id and band. Sits between the per-voice phase accumulators and the wavetable ROM.

Parameters:
NUM_VOICES, 8, number of requesting voices
MIDI_NOTES, 128, note range; NOTE_W = $clog2(MIDI_NOTES)
NUM_BANDS, 22, wavetable bands in ROM; BAND_W = $clog2(NUM_BANDS)
NOTES_PER_BAND, 6, semitones covered per band
PHASE_BITS, 10, samples per band table = 2**PHASE_BITS
SAMPLE_BITS, 16, ROM data width
ROM_LATENCY, 2, cycles from rom_en/rom_addr registered to rom_data valid (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_VOICES  per-voice request
req_note  in  NUM_VOICES*NOTE_W  voice i note at [i*NOTE_W +: NOTE_W]
req_phase  in  NUM_VOICES*PHASE_BITS  voice i phase index at [i*PHASE_BITS +: PHASE_BITS]
req_ready  out  NUM_VOICES  one-hot grant, combinational; transfer when req_valid[i] & req_ready[i]
rom_en  out  1  ROM read strobe, registered
rom_addr  out  BAND_W+PHASE_BITS  {band, phase}, registered
rom_data  in  SAMPLE_BITS  ROM read data, valid ROM_LATENCY cycles after rom_en
rsp_valid  out  1  response strobe, registered
rsp_voice  out  $clog2(NUM_VOICES)  voice id of response
rsp_band  out  BAND_W  band used for the read
rsp_sample  out  SAMPLE_BITS  sample returned

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset values: rom_en=0, rom_addr=0, rsp_valid=0, rsp_voice=0, rsp_band=0, rsp_sample=0, rr pointer=0, latency pipeline valid bits=0.
- Arbitration (combinational, cycle T):
  - Search req_valid starting at the rr pointer, upward with wrap.
  - The first asserted voice g gets req_ready[g]=1; all other bits are 0.
  - req_ready is never asserted for a voice whose req_valid=0.
- Pointer update: on a grant, pointer <= (g+1) mod NUM_VOICES. With no valid request the pointer holds and no grant is issued.
- Band mapping:
  - band = req_note[g] / NOTES_PER_BAND, integer division.
  - If the result is >= NUM_BANDS, band = NUM_BANDS-1.
  - Compute in NOTE_W bits, then truncate to BAND_W after the clamp.
- Cycle T+1: rom_en=1, rom_addr={band, req_phase[g]}. A side pipeline carries voice id g and band, depth ROM_LATENCY.
- Cycle T+1+ROM_LATENCY: rom_data is sampled.
- Cycle T+2+ROM_LATENCY: rsp_valid=1 with rsp_voice=g, rsp_band=band, rsp_sample=rom_data. This is 4 cycles after grant at defaults.
- Throughput: one grant and one response per cycle. Responses leave in grant order. There is no backpressure on rsp.
- Outputs on non-strobe cycles:
  - rom_en=0 cycles leave rom_addr holding its last value.
  - rsp_valid=0 cycles leave rsp_* fields holding their last value.
- A voice holding req_valid across a grant is simply re-eligible. Fairness: with all voices valid, each is granted exactly once per NUM_VOICES cycles.
- Inputs req_note/req_phase of the granted voice are sampled only in the grant cycle. Later changes do not affect in-flight reads.
- Reset mid-operation: all in-flight reads are discarded. No rsp_valid emerges after rst_n deasserts until new grants traverse the pipeline. The pointer returns to 0.

Test Plan:
- Single request: voice 3, note 60, phase 0x155, at T -> req_ready=8'h08 at T; rom_en=1 and rom_addr={5'd10,10'h155} at T+1; rsp_valid at T+4 with voice 3, band 10, sample = ROM model[10][0x155].
- All 8 voices valid for 20 cycles -> grant order 0,1,…,7,0,1,…; rsp_voice follows the same order 4 cycles later; one rsp per cycle with no gaps.
- Band boundaries: notes 0, 5, 6, 127 -> bands 0, 0, 1, 21. With NUM_BANDS=20, note 127 -> band 19 (clamped).
- Pointer behaviour:
  - Grant voice 2, then 3 idle cycles, then voices 1 and 5 valid -> voice 5 granted first, then voice 1; rom_en=0 during the idle cycles.
  - A pattern with no requests -> no req_ready bit is ever set.
- Reset mid-flight: grant voices 0 and 1 on consecutive cycles, assert rst_n=0 one cycle later for 2 cycles -> rsp_valid stays 0 through and after reset; all outputs are at reset values asynchronously.
- ROM_LATENCY=1 build: single request -> rsp_valid 3 cycles after grant with correct tagging.
